// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit, iterative shift-add multiply and restoring divide
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LOAD = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] d, hi, lo;
  logic neg, neg_r;
  logic accept, is_div, sa, sb, div_zero, ovf, early;
  logic [WIDTH-1:0] ma, mb, early_res;
  logic [2*WIDTH-1:0] fp, fps;
  logic [WIDTH:0] mul_sum, div_sh;
  logic [WIDTH-1:0] div_diff, hi_n, lo_n, quo, rem, run_res;
  logic div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  always_comb begin
    is_div    = funct3[2];
    sa        = op_a[WIDTH-1] & (is_div ? ~funct3[0] : ^funct3[1:0]);
    sb        = op_b[WIDTH-1] & (is_div ? ~funct3[0] : funct3[1:0] == 2'b01);
    ma        = sa ? -op_a : op_a;
    mb        = sb ? -op_b : op_b;
    div_zero  = is_div && op_b == '0;
    ovf       = is_div && !funct3[0] && op_a == MIN && op_b == '1;
    early     = div_zero || ovf || (FAST_MUL && !is_div);
    fp        = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
    fps       = (sa ^ sb) ? -fp : fp;
    early_res = div_zero ? (funct3[1] ? op_a : '1) :
                ovf ? (funct3[1] ? '0 : op_a) :
                (funct3[1:0] == 2'b00 ? fps[WIDTH-1:0] : fps[2*WIDTH-1:WIDTH]);
    accept    = state != RUN && start && !flush;
    state_n   = state == RUN ? (flush ? IDLE : cnt == ONE ? FIN : RUN) :
                accept ? (early ? FIN : RUN) : IDLE;
    busy      = state == RUN;
    done      = state == FIN;
  end
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, d};
    div_diff = div_sh[WIDTH-1:0] - d;
    hi_n     = op[2] ? (div_ge ? div_diff : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    lo_n     = op[2] ? {lo[WIDTH-2:0], div_ge} : {mul_sum[0], lo[WIDTH-1:1]};
    prod     = {hi_n, lo_n};
    prod_s   = neg ? -prod : prod;
    quo      = neg ? -lo_n : lo_n;
    rem      = neg_r ? -hi_n : hi_n;
    run_res  = op[2] ? (op[1] ? rem : quo) :
               (op[1:0] == 2'b00 ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op     <= '0;
      d      <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt    <= LOAD;
      op     <= funct3;
      d      <= is_div ? mb : ma;
      hi     <= '0;
      lo     <= is_div ? ma : mb;
      neg    <= sa ^ sb;
      neg_r  <= sa;
      if (early) result <= early_res;
    end else if (state == RUN) begin
      cnt <= cnt - ONE;
      hi  <= hi_n;
      lo  <= lo_n;
      if (cnt == ONE && !flush) result <= run_res;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0, start_f = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy_s, done_s, busy_f, done_f;
  logic [31:0] result_s, result_f;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start_s), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy_s), .done(done_s), .result(result_s)
  );
  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy_f), .done(done_f), .result(result_f)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    model = '0;
    case (f)
      3'd0: begin p = ua * ub; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: model = b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5: model = b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: model = b == 0 ? a : 32'(sa % sb);
      default: model = b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input bit fast, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit e;
    e = (fast && !f[2]) || (f[2] && b == 0) || (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    exp_lat = e ? 1 : 33;
  endfunction
  task automatic do_op(input bit fast, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit busy_ok);
    funct3 = f;
    op_a = a;
    op_b = b;
    if (fast) start_f = 1'b1; else start_s = 1'b1;
    tick();
    start_s = 1'b0;
    start_f = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while ((fast ? done_f : done_s) !== 1'b1 && lat < 100) begin
      if ((fast ? busy_f : busy_s) !== 1'b1) busy_ok = 1'b0;
      funct3 = 3'($urandom);
      op_a = $urandom;
      op_b = $urandom;
      tick();
      lat++;
    end
    if ((fast ? busy_f : busy_s) !== 1'b0) busy_ok = 1'b0;
    res = fast ? result_f : result_s;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_s); end
    n_tests++; if (done_s !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_s); end
    n_tests++; if (result_s !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result_s); end
    n_tests++; if (result_f !== 32'h0) begin n_fail++; $display("FAIL reset_result_f got %h exp 0", result_f); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_directed();
    logic [2:0] vf[14];
    logic [31:0] va[14], vb[14], vr[14];
    int vl[14];
    logic [31:0] res;
    int lat;
    bit bok;
    vf = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    va = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
           32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    vb = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
           32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vr = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
           32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    vl = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 14; i++) begin
      do_op(1'b0, vf[i], va[i], vb[i], res, lat, bok);
      n_tests++; if (res !== vr[i]) begin n_fail++; $display("FAIL dir_result[%0d] got %h exp %h", i, res, vr[i]); end
      n_tests++; if (lat !== vl[i]) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, vl[i]); end
      n_tests++; if (!bok) begin n_fail++; $display("FAIL dir_busy[%0d] got bad busy profile exp busy only in cycles 1..%0d", i, vl[i] - 1); end
    end
  endtask
  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b, res;
    int lat, mode;
    bit bok;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (mode == 3) b = 32'($signed(-$urandom_range(1, 20)));
      do_op(1'b0, f, a, b, res, lat, bok);
      n_tests++; if (res !== model(f, a, b)) begin n_fail++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h got %h exp %h", i, f, a, b, res, model(f, a, b)); end
      n_tests++; if (lat !== exp_lat(1'b0, f, a, b)) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, exp_lat(1'b0, f, a, b)); end
      n_tests++; if (!bok) begin n_fail++; $display("FAIL rand_busy[%0d] got bad busy profile", i); end
    end
  endtask
  task automatic test_fast();
    logic [2:0] f;
    logic [31:0] a, b, res;
    int lat;
    bit bok;
    do_op(1'b1, 3'd0, 32'h10000, 32'h10000, res, lat, bok);
    n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL fast_mul got %h exp 0", res); end
    n_tests++; if (lat !== 1 || !bok) begin n_fail++; $display("FAIL fast_mul_latency got %0d busy_ok %b exp 1 busy_ok 1", lat, bok); end
    do_op(1'b1, 3'd3, 32'h10000, 32'h10000, res, lat, bok);
    n_tests++; if (res !== 32'h1) begin n_fail++; $display("FAIL fast_mulhu got %h exp 1", res); end
    n_tests++; if (lat !== 1 || !bok) begin n_fail++; $display("FAIL fast_mulhu_latency got %0d busy_ok %b exp 1 busy_ok 1", lat, bok); end
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i == 0) ? 32'd0 : $urandom;
      do_op(1'b1, f, a, b, res, lat, bok);
      n_tests++; if (res !== model(f, a, b)) begin n_fail++; $display("FAIL fast_rand_result[%0d] f=%0d got %h exp %h", i, f, res, model(f, a, b)); end
      n_tests++; if (lat !== exp_lat(1'b1, f, a, b) || !bok) begin n_fail++; $display("FAIL fast_rand_latency[%0d] got %0d exp %0d", i, lat, exp_lat(1'b1, f, a, b)); end
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, res;
    int lat;
    bit bok;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    do_op(1'b0, 3'd3, a1, b1, res, lat, bok);
    n_tests++; if (res !== model(3'd3, a1, b1) || lat !== 33) begin n_fail++; $display("FAIL b2b_first got %h lat %0d exp %h lat 33", res, lat, model(3'd3, a1, b1)); end
    do_op(1'b0, 3'd6, a2, b2, res, lat, bok);
    n_tests++; if (res !== model(3'd6, a2, b2) || lat !== 33 || !bok) begin n_fail++; $display("FAIL b2b_second got %h lat %0d exp %h lat 33", res, lat, model(3'd6, a2, b2)); end
  endtask
  task automatic test_start_while_busy();
    int lat, extra;
    start_s = 1'b0;
    tick();
    funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFFFFFD; start_s = 1'b1;
    tick();
    lat = 1;
    while (done_s !== 1'b1 && lat < 100) begin
      if (lat == 5) begin start_s = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; end
      else start_s = 1'b0;
      tick();
      lat++;
    end
    start_s = 1'b0;
    n_tests++; if (result_s !== 32'hFFFFFFEB || lat !== 33) begin n_fail++; $display("FAIL busy_start got %h lat %0d exp ffffffeb lat 33", result_s, lat); end
    extra = 0;
    repeat (40) begin tick(); if (done_s === 1'b1 || busy_s === 1'b1) extra++; end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_start_queued got %0d active cycles exp 0", extra); end
  endtask
  task automatic test_flush();
    logic [31:0] res;
    int lat, dones;
    bit bok;
    do_op(1'b0, 3'd0, 32'd7, 32'hFFFFFFFD, res, lat, bok);
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    dones = 0;
    repeat (9) begin tick(); if (done_s === 1'b1) dones++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b exp 0", busy_s); end
    n_tests++; if (done_s !== 1'b0 || dones !== 0) begin n_fail++; $display("FAIL flush_done got %b (%0d early) exp 0", done_s, dones); end
    n_tests++; if (result_s !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL flush_result got %h exp ffffffeb", result_s); end
    do_op(1'b0, 3'd5, 32'd100, 32'd7, res, lat, bok);
    n_tests++; if (res !== 32'd14 || lat !== 33 || !bok) begin n_fail++; $display("FAIL flush_restart got %h lat %0d exp 0000000e lat 33", res, lat); end
    funct3 = 3'd7; op_a = 32'd9; op_b = 32'd4; start_s = 1'b1; flush = 1'b1;
    tick();
    start_s = 1'b0; flush = 1'b0;
    n_tests++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin n_fail++; $display("FAIL flush_fin_start got busy %b done %b exp 0 0", busy_s, done_s); end
    funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0; start_s = 1'b1; flush = 1'b1;
    tick();
    start_s = 1'b0; flush = 1'b0;
    tick();
    n_tests++; if (busy_s !== 1'b0 || done_s !== 1'b0 || result_s !== 32'd14) begin n_fail++; $display("FAIL flush_idle_start got busy %b done %b result %h exp 0 0 0000000e", busy_s, done_s, result_s); end
  endtask
  task automatic test_rst_mid();
    int act;
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got busy %b done %b exp 0 0", busy_s, done_s); end
    n_tests++; if (result_s !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result got %h exp 0", result_s); end
    act = 0;
    repeat (40) begin tick(); if (done_s === 1'b1 || busy_s === 1'b1) act++; end
    n_tests++; if (act !== 0) begin n_fail++; $display("FAIL rst_mid_after got %0d active cycles exp 0", act); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_flush();
    test_rst_mid();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
